// File: rtl/alu_pipe.sv
// Pipelined integer ALU between a reservation-station queue and the CDB, with credit-based issue.
// Optional `ALU_FLUSH_EN adds the alu_flush port, which discards all in-flight results.
module alu_pipe #(
  parameter int ROB_ENTRY   = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int PIPE_STAGES = 2,
  parameter int OUT_DEPTH   = 2,
  localparam int ROB_ID_W    = $clog2(ROB_ENTRY),
  localparam int RSV_Q_WIDTH = OP_WIDTH + 2*DATA_WIDTH + ROB_ID_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sync_q_rok,
  input  logic [RSV_Q_WIDTH-1:0] sync_q_rdata,
  output logic                   sync_q_ren,
  output logic                   cdb_isr_request,
  output logic [DATA_WIDTH-1:0]  cdb_isr_data,
  output logic [ROB_ID_W-1:0]    cdb_isr_id,
  input  logic                   cdb_isr_grant
`ifdef ALU_FLUSH_EN
  ,
  input  logic                   alu_flush
`endif
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCC_W   = $clog2(OUT_DEPTH + 1);

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD  = OP_WIDTH'(0),
    OP_SUB  = OP_WIDTH'(1),
    OP_SLT  = OP_WIDTH'(2),
    OP_SLTU = OP_WIDTH'(3),
    OP_AND  = OP_WIDTH'(4),
    OP_OR   = OP_WIDTH'(5),
    OP_XOR  = OP_WIDTH'(6),
    OP_SLL  = OP_WIDTH'(7),
    OP_SRL  = OP_WIDTH'(8),
    OP_SRA  = OP_WIDTH'(9)
  } alu_op_e;

  logic flush;
`ifdef ALU_FLUSH_EN
  assign flush = alu_flush;
`else
  assign flush = 1'b0;
`endif

  logic [OP_WIDTH-1:0]   q_op;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;
  logic [ROB_ID_W-1:0]   q_id;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_res;

  assign q_op  = sync_q_rdata[RSV_Q_WIDTH-1 -: OP_WIDTH];
  assign q_a   = sync_q_rdata[ROB_ID_W+DATA_WIDTH +: DATA_WIDTH];
  assign q_b   = sync_q_rdata[ROB_ID_W +: DATA_WIDTH];
  assign q_id  = sync_q_rdata[ROB_ID_W-1:0];
  assign shamt = q_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (q_op)
      OP_ADD:  alu_res = q_a + q_b;
      OP_SUB:  alu_res = q_a - q_b;
      OP_SLT:  alu_res = DATA_WIDTH'($signed(q_a) < $signed(q_b));
      OP_SLTU: alu_res = DATA_WIDTH'(q_a < q_b);
      OP_AND:  alu_res = q_a & q_b;
      OP_OR:   alu_res = q_a | q_b;
      OP_XOR:  alu_res = q_a ^ q_b;
      OP_SLL:  alu_res = q_a << shamt;
      OP_SRL:  alu_res = q_a >> shamt;
      OP_SRA:  alu_res = $signed(q_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  logic [OCC_W-1:0] occ;
  logic             q_hs;
  logic             cdb_hs;
  logic             fifo_ne;

  assign cdb_isr_request = fifo_ne & ~flush;
  assign cdb_hs          = cdb_isr_request & cdb_isr_grant;
  // A retire in this cycle frees a credit, so a full pipe can still issue.
  assign sync_q_ren      = sync_q_rok & ~RST & ~flush &
                           ((occ < OCC_W'(OUT_DEPTH)) | cdb_hs);
  assign q_hs            = sync_q_ren;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      occ <= '0;
    end else begin
      case ({q_hs, cdb_hs})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  logic                  wr_v;
  logic [DATA_WIDTH-1:0] wr_d;
  logic [ROB_ID_W-1:0]   wr_id;

  generate
    if (PIPE_STAGES == 1) begin : g_nopipe
      assign wr_v  = q_hs;
      assign wr_d  = alu_res;
      assign wr_id = q_id;
    end else begin : g_pipe
      logic                  stg_v  [PIPE_STAGES-1];
      logic [DATA_WIDTH-1:0] stg_d  [PIPE_STAGES-1];
      logic [ROB_ID_W-1:0]   stg_id [PIPE_STAGES-1];

      always_ff @(posedge CLK) begin
        if (RST || flush) begin
          for (int unsigned i = 0; i < PIPE_STAGES-1; i++) stg_v[i] <= 1'b0;
        end else begin
          stg_v[0] <= q_hs;
          for (int unsigned i = 1; i < PIPE_STAGES-1; i++) stg_v[i] <= stg_v[i-1];
        end
        stg_d[0]  <= alu_res;
        stg_id[0] <= q_id;
        for (int unsigned i = 1; i < PIPE_STAGES-1; i++) begin
          stg_d[i]  <= stg_d[i-1];
          stg_id[i] <= stg_id[i-1];
        end
      end

      assign wr_v  = stg_v[PIPE_STAGES-2];
      assign wr_d  = stg_d[PIPE_STAGES-2];
      assign wr_id = stg_id[PIPE_STAGES-2];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] fifo_d  [OUT_DEPTH];
  logic [ROB_ID_W-1:0]   fifo_id [OUT_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [OCC_W-1:0]      fifo_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_ne = (fifo_cnt != '0);

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_v) begin
        fifo_d[wptr]  <= wr_d;
        fifo_id[wptr] <= wr_id;
        wptr          <= ptr_inc(wptr);
      end
      if (cdb_hs) rptr <= ptr_inc(rptr);
      case ({wr_v, cdb_hs})
        2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign cdb_isr_data = fifo_ne ? fifo_d[rptr]  : '0;
  assign cdb_isr_id   = fifo_ne ? fifo_id[rptr] : '0;

endmodule
